// File: rtl/dmem_pkg.sv
// Shared definitions for the byte-addressable big-endian data memory controller:
// access-size encodings, FSM states and byte-lane helpers.
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    // be[3] is bits [31:24], which holds the byte at word offset 0 (big-endian).
    function automatic logic [3:0] be_from_size(input logic [1:0] size, input logic [1:0] a);
        logic [3:0] be;
        case (size)
            SZ_BYTE: be = 4'b1000 >> a;
            SZ_HALF: be = a[1] ? 4'b0011 : 4'b1100;
            SZ_WORD: be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    function automatic logic is_bad_access(input logic [1:0] size, input logic [1:0] a);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = a[0];
            SZ_WORD: bad = (a != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-organised storage with per-byte write enables and a combinational read
// of the addressed word. Contents are deliberately not reset.
module dmem_array #(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [3:0]        be_i,
    input  logic [ADDR_W-3:0] widx_i,
    input  logic [31:0]       wdata_i,
    output logic [31:0]       rdata_o
);

    logic [31:0] mem_q [2**(ADDR_W-2)];

    always_ff @(posedge clk) begin
        if (we_i) begin
            for (int i = 0; i < 4; i++) begin
                if (be_i[i]) mem_q[widx_i][8*i +: 8] <= wdata_i[8*i +: 8];
            end
        end
    end

    assign rdata_o = mem_q[widx_i];

endmodule

// File: rtl/dmem_ctrl.sv
// Data memory controller: request latch, IDLE/WAIT/COMMIT sequencing with
// configurable wait states, big-endian lane steering, load extension and alignment errors.
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int ADDR_W      = 12,
    parameter int DATA_W      = 32,
    parameter int WAIT_STATES = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              dm_cs,
    input  logic              dm_rd,
    input  logic              dm_wr,
    input  logic [1:0]        dm_size,
    input  logic              dm_sext,
    input  logic [31:0]       Addr,
    input  logic [DATA_W-1:0] DM_In,
    output logic [DATA_W-1:0] DM_Out,
    output logic              dm_busy,
    output logic              dm_ready,
    output logic              dm_err
);

    if (DATA_W != 32) begin : g_bad_data_w
        $error("dmem_ctrl: DATA_W must be 32");
    end
    if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_bad_wait
        $error("dmem_ctrl: WAIT_STATES must be 0..15");
    end
    if (ADDR_W < 2 || ADDR_W > 32) begin : g_bad_addr_w
        $error("dmem_ctrl: ADDR_W must be 2..32");
    end

    localparam logic [3:0] CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] dout_q, dout_d;
    logic        err_q, err_d;

    logic [ADDR_W-1:0] addr_q;
    logic [1:0]        size_q;
    logic              sext_q;
    logic              wr_q;
    logic [31:0]       data_q;

    logic accept;
    assign accept = (state_q == ST_IDLE) && dm_cs && (dm_rd ^ dm_wr);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (WAIT_STATES == 0) begin
                        state_d = ST_COMMIT;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) state_d = ST_COMMIT;
                else               cnt_d   = cnt_q - 4'd1;
            end
            ST_COMMIT: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // The access happens on the edge entering COMMIT so DM_Out is valid alongside
    // dm_ready. With no wait states that edge is the accepting edge itself, so the
    // live inputs are used instead of the (not yet loaded) latch.
    logic              use_live;
    logic              commit_go;
    logic [ADDR_W-1:0] acc_addr;
    logic [1:0]        acc_size;
    logic              acc_sext;
    logic              acc_wr;
    logic [31:0]       acc_data;
    logic              acc_err;

    assign use_live  = (state_q == ST_IDLE);
    assign commit_go = (state_d == ST_COMMIT);
    assign acc_addr  = use_live ? Addr[ADDR_W-1:0] : addr_q;
    assign acc_size  = use_live ? dm_size : size_q;
    assign acc_sext  = use_live ? dm_sext : sext_q;
    assign acc_wr    = use_live ? dm_wr   : wr_q;
    assign acc_data  = use_live ? DM_In   : data_q;
    assign acc_err   = is_bad_access(acc_size, acc_addr[1:0]);

    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_we;

    assign mem_be = be_from_size(acc_size, acc_addr[1:0]);
    assign mem_we = commit_go && acc_wr && !acc_err;

    // Replicating the right-justified value across lanes lets the byte enables pick the slot.
    always_comb begin
        case (acc_size)
            SZ_BYTE: mem_wdata = {4{acc_data[7:0]}};
            SZ_HALF: mem_wdata = {2{acc_data[15:0]}};
            default: mem_wdata = acc_data;
        endcase
    end

    dmem_array #(.ADDR_W(ADDR_W)) u_array (
        .clk     (clk),
        .we_i    (mem_we),
        .be_i    (mem_be),
        .widx_i  (acc_addr[ADDR_W-1:2]),
        .wdata_i (mem_wdata),
        .rdata_o (mem_rdata)
    );

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_val;

    assign ld_byte = mem_rdata[8*(3 - acc_addr[1:0]) +: 8];
    assign ld_half = acc_addr[1] ? mem_rdata[15:0] : mem_rdata[31:16];

    always_comb begin
        case (acc_size)
            SZ_BYTE: ld_val = {{24{acc_sext & ld_byte[7]}}, ld_byte};
            SZ_HALF: ld_val = {{16{acc_sext & ld_half[15]}}, ld_half};
            default: ld_val = mem_rdata;
        endcase
    end

    always_comb begin
        dout_d = dout_q;
        err_d  = err_q;
        if (commit_go) begin
            err_d = acc_err;
            if (!acc_wr && !acc_err) dout_d = ld_val;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            dout_q  <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            addr_q <= Addr[ADDR_W-1:0];
            size_q <= dm_size;
            sext_q <= dm_sext;
            wr_q   <= dm_wr;
            data_q <= DM_In;
        end
    end

    logic unused_addr_hi;
    assign unused_addr_hi = ^Addr;

    assign DM_Out   = dout_q;
    assign dm_busy  = (state_q != ST_IDLE);
    assign dm_ready = (state_q == ST_COMMIT);
    assign dm_err   = (state_q == ST_COMMIT) && err_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Randomised scoreboard bench for dmem_ctrl: one instance with one wait state and
// one with none, sharing a stimulus bus, checked against a byte-array memory model.
module tb_dmem_ctrl;

    localparam int AW = 12;
    localparam int MSZ = 2**AW;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cs = 1'b0, rd = 1'b0, wr = 1'b0, sext = 1'b0;
    logic [1:0]  size = 2'b00;
    logic [31:0] addr = 32'd0, din = 32'd0;
    int          sel = 0;

    logic [31:0] do0, do1;
    logic        busy0, busy1, rdy0, rdy1, err0, err1;
    logic        cs0, cs1;

    assign cs0 = cs && (sel == 0);
    assign cs1 = cs && (sel == 1);

    always #5 clk = ~clk;

    dmem_ctrl #(.ADDR_W(AW), .DATA_W(32), .WAIT_STATES(1)) dut0 (
        .clk(clk), .reset_n(reset_n), .dm_cs(cs0), .dm_rd(rd), .dm_wr(wr),
        .dm_size(size), .dm_sext(sext), .Addr(addr), .DM_In(din),
        .DM_Out(do0), .dm_busy(busy0), .dm_ready(rdy0), .dm_err(err0));

    dmem_ctrl #(.ADDR_W(AW), .DATA_W(32), .WAIT_STATES(0)) dut1 (
        .clk(clk), .reset_n(reset_n), .dm_cs(cs1), .dm_rd(rd), .dm_wr(wr),
        .dm_size(size), .dm_sext(sext), .Addr(addr), .DM_In(din),
        .DM_Out(do1), .dm_busy(busy1), .dm_ready(rdy1), .dm_err(err1));

    logic [31:0] do_m;
    logic        busy_m, rdy_m, err_m;
    assign do_m   = (sel == 1) ? do1   : do0;
    assign busy_m = (sel == 1) ? busy1 : busy0;
    assign rdy_m  = (sel == 1) ? rdy1  : rdy0;
    assign err_m  = (sel == 1) ? err1  : err0;

    int ws_of[2] = '{1, 0};

    // Reference model: plain byte array per instance plus the last value DM_Out should show.
    logic [7:0]  mdl [2][MSZ];
    logic [31:0] last_out [2];

    typedef struct {
        logic        err;
        logic [31:0] dout;
    } exp_t;
    exp_t sbq[$];

    int n_cmp = 0;
    int n_fail = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic model_err(input logic [1:0] sz, input int a);
        if (sz == 2'd3) return 1'b1;
        return (a % nbytes(sz)) != 0;
    endfunction

    function automatic logic [31:0] model_load(input int s, input logic [1:0] sz, input logic sx, input int a);
        int n;
        logic [31:0] v;
        n = nbytes(sz);
        v = 32'd0;
        for (int i = 0; i < n; i++) v = (v << 8) | 32'(mdl[s][a + i]);
        if (n < 4 && sx && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
        return v;
    endfunction

    task automatic model_store(input int s, input logic [1:0] sz, input int a, input logic [31:0] d);
        int n;
        n = nbytes(sz);
        for (int i = 0; i < n; i++) mdl[s][a + i] = 8'(d >> (8*(n-1-i)));
    endtask

    task automatic do_req(input logic w, input logic [1:0] sz, input logic sx,
                          input logic [31:0] a32, input logic [31:0] d, input bit noise);
        int   a;
        int   n;
        bit   got;
        exp_t e;
        @(negedge clk);
        a = int'(a32[AW-1:0]);
        e.err = model_err(sz, a);
        if (!e.err) begin
            if (w) model_store(sel, sz, a, d);
            else   last_out[sel] = model_load(sel, sz, sx, a);
        end
        e.dout = last_out[sel];
        sbq.push_back(e);
        cs = 1'b1; rd = !w; wr = w; size = sz; sext = sx; addr = a32; din = d;
        @(posedge clk);
        n = 0;
        got = 0;
        while (!got && n < 40) begin
            @(negedge clk);
            n++;
            check("busy_in_flight", {31'd0, busy_m}, 32'd1);
            if (rdy_m) got = 1;
            if (got || !noise) begin
                cs = 1'b0;
            end else begin
                cs = 1'b1; rd = 1'($urandom); wr = 1'($urandom);
                size = 2'($urandom); addr = $urandom; din = $urandom; sext = 1'($urandom);
            end
        end
        check("ready_seen", {31'd0, got}, 32'd1);
        check("latency", 32'(n), 32'(ws_of[sel] + 1));
    endtask

    // Monitor: every ready pulse consumes one expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rdy_m) begin
                if (sbq.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL spurious_ready: got ready with no request outstanding (t=%0t)", $time);
                end else begin
                    e = sbq.pop_front();
                    check("dm_err", {31'd0, err_m}, {31'd0, e.err});
                    check("DM_Out", do_m, e.dout);
                end
            end else if (err_m) begin
                n_cmp++;
                n_fail++;
                $display("FAIL err_without_ready: got dm_err=1, expected 0 (t=%0t)", $time);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, expected $finish before timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  sz;
        logic [31:0] a32;
        last_out[0] = 32'd0;
        last_out[1] = 32'd0;

        repeat (2) @(negedge clk);
        check("rst_busy0", {31'd0, busy0}, 32'd0);
        check("rst_ready0", {31'd0, rdy0}, 32'd0);
        check("rst_err0", {31'd0, err0}, 32'd0);
        check("rst_dout0", do0, 32'd0);
        check("rst_dout1", do1, 32'd0);
        check("rst_busy1", {31'd0, busy1}, 32'd0);
        reset_n = 1'b1;

        // Fill both memories so every later load has a known expectation.
        for (int s = 0; s < 2; s++) begin
            sel = s;
            for (int w = 0; w < MSZ / 4; w++)
                do_req(1'b1, 2'd2, 1'b0, {$urandom_range(0, 255), 24'd0} | 32'(w * 4), $urandom, 1'b0);
        end

        sel = 0;
        do_req(1'b1, 2'd2, 1'b0, 32'h010, 32'hDEAD_BEEF, 1'b0);
        do_req(1'b0, 2'd2, 1'b0, 32'h010, 32'h0, 1'b0);
        do_req(1'b0, 2'd0, 1'b1, 32'h010, 32'h0, 1'b0);
        do_req(1'b1, 2'd0, 1'b0, 32'h013, 32'hAAAA_AA7F, 1'b0);
        do_req(1'b0, 2'd2, 1'b0, 32'h010, 32'h0, 1'b0);
        do_req(1'b0, 2'd1, 1'b0, 32'h012, 32'h0, 1'b0);
        do_req(1'b0, 2'd1, 1'b1, 32'h012, 32'h0, 1'b0);
        do_req(1'b0, 2'd2, 1'b0, 32'h011, 32'h0, 1'b0);
        do_req(1'b1, 2'd1, 1'b0, 32'h015, 32'h1234_5678, 1'b0);
        do_req(1'b1, 2'd3, 1'b0, 32'h014, 32'h1234_5678, 1'b1);
        do_req(1'b0, 2'd2, 1'b0, 32'h014, 32'h0, 1'b0);
        do_req(1'b1, 2'd2, 1'b0, 32'h1004, 32'h1234_5678, 1'b1);
        do_req(1'b0, 2'd2, 1'b0, 32'h004, 32'h0, 1'b0);
        sel = 1;
        do_req(1'b1, 2'd2, 1'b0, 32'h1004, 32'h1234_5678, 1'b0);
        do_req(1'b0, 2'd2, 1'b0, 32'h004, 32'h0, 1'b0);
        do_req(1'b0, 2'd0, 1'b1, 32'h007, 32'h0, 1'b0);

        // Illegal simultaneous read/write: must stay idle with no ready.
        for (int s = 0; s < 2; s++) begin
            sel = s;
            @(negedge clk);
            cs = 1'b1; rd = 1'b1; wr = 1'b1; addr = 32'h020; size = 2'd2;
            repeat (3) begin
                @(negedge clk);
                check("illegal_busy", {31'd0, busy_m}, 32'd0);
            end
            cs = 1'b0; rd = 1'b0; wr = 1'b0;
        end

        // Reset during the WAIT of a store: the store must not land.
        sel = 0;
        @(negedge clk);
        cs = 1'b1; rd = 1'b0; wr = 1'b1; size = 2'd2; addr = 32'h020; din = 32'hCAFE_F00D;
        @(posedge clk);
        @(negedge clk);
        cs = 1'b0;
        check("wait_busy", {31'd0, busy0}, 32'd1);
        reset_n = 1'b0;
        #1;
        check("midrst_busy", {31'd0, busy0}, 32'd0);
        check("midrst_ready", {31'd0, rdy0}, 32'd0);
        check("midrst_err", {31'd0, err0}, 32'd0);
        check("midrst_dout0", do0, 32'd0);
        check("midrst_dout1", do1, 32'd0);
        last_out[0] = 32'd0;
        last_out[1] = 32'd0;
        @(negedge clk);
        reset_n = 1'b1;
        do_req(1'b0, 2'd2, 1'b0, 32'h020, 32'h0, 1'b0);

        // Randomised mix, mostly aligned, with bus noise while busy.
        for (int s = 0; s < 2; s++) begin
            sel = s;
            for (int k = 0; k < 250; k++) begin
                sz = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
                a32 = $urandom;
                if ($urandom_range(0, 3) != 0) begin
                    if (sz == 2'd2) a32[1:0] = 2'b00;
                    if (sz == 2'd1) a32[0] = 1'b0;
                end
                do_req(1'($urandom), sz, 1'($urandom), a32, $urandom, 1'($urandom));
            end
        end

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 32'(sbq.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
